// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: data/stack memory for the pipeline memory stage.
// Serves 1-word and 2-word accesses over a valid/ready request port and
// returns a registered one-cycle completion strobe. A 2-word access is
// split into two sequential word beats. Out-of-range addresses are
// reported on rsp_err and never alias into the array.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   req_valid  request present
//   req_ready  controller accepts a request this cycle
//   req_write  1 = write, 0 = read
//   req_wide   1 = 2-word access, 0 = 1-word access
//   req_addr   word address of the (first) word
//   req_wdata  write data; narrow uses the low word
//   rsp_valid  one-cycle completion strobe
//   rsp_err    qualifies rsp_valid: access was out of range
//   rsp_rdata  read data, valid with rsp_valid on reads
//   busy       access in flight (inverse of req_ready)
module data_mem_ctrl #(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DEPTH_LOG2 = 11
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic                req_wide,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [2*DATA_W-1:0] req_wdata,
    output logic                rsp_valid,
    output logic                rsp_err,
    output logic [2*DATA_W-1:0] rsp_rdata,
    output logic                busy
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    // A wide access needs addr+1 in range too, so its limit is one lower.
    localparam logic [ADDR_W-1:0] LIM_NARROW = ADDR_W'(DEPTH);
    localparam logic [ADDR_W-1:0] LIM_WIDE   = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT0 = 2'd1,
        BEAT1 = 2'd2
    } state_t;

    state_t                  state;
    logic                    wr_q;
    logic                    wide_q;
    logic                    err_q;
    logic [DEPTH_LOG2-1:0]   idx_q;
    logic [2*DATA_W-1:0]     wdata_q;
    logic [DATA_W-1:0]       hi_q;

    logic [DATA_W-1:0]       mem [DEPTH];

    logic [DEPTH_LOG2-1:0]   mem_idx;
    logic                    mem_we;
    logic [DATA_W-1:0]       mem_wd;
    logic [DATA_W-1:0]       rd_word;

    // Beat addressing and write-enable for the array.
    always_comb begin
        mem_idx = idx_q;
        mem_we  = 1'b0;
        mem_wd  = wdata_q[DATA_W-1:0];
        if (state == BEAT1) begin
            mem_idx = idx_q + DEPTH_LOG2'(1);
        end
        if ((state == BEAT0) && wide_q) begin
            mem_wd = wdata_q[2*DATA_W-1:DATA_W];
        end
        if ((state != IDLE) && wr_q && !err_q) begin
            mem_we = 1'b1;
        end
        rd_word = mem[mem_idx];
    end

    // Array storage; contents deliberately not reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_idx] <= mem_wd;
        end
    end

    // Access sequencer with registered handshake and response outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            busy      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
            wr_q      <= 1'b0;
            wide_q    <= 1'b0;
            err_q     <= 1'b0;
            idx_q     <= '0;
            wdata_q   <= '0;
            hi_q      <= '0;
        end else begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        wr_q      <= req_write;
                        wide_q    <= req_wide;
                        idx_q     <= req_addr[DEPTH_LOG2-1:0];
                        wdata_q   <= req_wdata;
                        err_q     <= req_wide ? (req_addr >= LIM_WIDE)
                                              : (req_addr >= LIM_NARROW);
                        state     <= BEAT0;
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                BEAT0: begin
                    if (err_q || !wide_q) begin
                        state     <= IDLE;
                        req_ready <= 1'b1;
                        busy      <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= err_q;
                        if (err_q) begin
                            rsp_rdata <= '0;
                        end else if (!wr_q) begin
                            rsp_rdata <= {DATA_W'(0), rd_word};
                        end
                    end else begin
                        // Hold the high word until the response so rsp_rdata
                        // does not change between responses.
                        hi_q  <= rd_word;
                        state <= BEAT1;
                    end
                end
                BEAT1: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                    busy      <= 1'b0;
                    rsp_valid <= 1'b1;
                    if (!wr_q) begin
                        rsp_rdata <= {hi_q, rd_word};
                    end
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Scoreboard bench for data_mem_ctrl: expected responses are queued at
// request acceptance and compared when rsp_valid strobes.
module tb_data_mem_ctrl;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic        req_wide;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_err;
    logic [31:0] rsp_rdata;
    logic        busy;

    data_mem_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_wide  (req_wide),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_err   (rsp_err),
        .rsp_rdata (rsp_rdata),
        .busy      (busy)
    );

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] mdl [2048];
    logic [31:0] last_rd;
    int          cyc;
    int          n_checks;
    int          n_errors;
    int          n_issued;
    int          n_rsp;
    int          acc_cyc[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Response monitor: every strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n && rsp_valid) begin
            n_rsp++;
            if (sb.size() == 0) begin
                check("unexpected_rsp", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("rsp_err",   32'(rsp_err), 32'(e.err));
                check("rsp_rdata", rsp_rdata, e.rdata);
                check("latency",   32'(cyc), 32'(e.cyc));
                check("ready_w_rsp", {30'd0, req_ready, busy}, 32'd2);
            end
        end
    end

    // Issue one request, wait for acceptance, queue its expected response.
    task automatic issue(input logic w, input logic wd, input logic [31:0] a,
                         input logic [31:0] d, input logic hold);
        int   n;
        int   k;
        exp_t e;
        logic err;
        req_write = w;
        req_wide  = wd;
        req_addr  = a;
        req_wdata = d;
        req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            check("accept_timeout", 32'd0, 32'd1);
            req_valid = 1'b0;
            return;
        end
        k   = cyc;
        err = wd ? (a >= 32'd2047) : (a >= 32'd2048);
        e.err = err;
        e.cyc = k + ((wd && !err) ? 3 : 2);
        if (err) begin
            last_rd = 32'd0;
        end else if (w) begin
            if (wd) begin
                mdl[a[10:0]]         = d[31:16];
                mdl[a[10:0] + 11'd1] = d[15:0];
            end else begin
                mdl[a[10:0]] = d[15:0];
            end
        end else begin
            last_rd = wd ? {mdl[a[10:0]], mdl[a[10:0] + 11'd1]} : {16'd0, mdl[a[10:0]]};
        end
        e.rdata = last_rd;
        @(posedge clk);
        sb.push_back(e);
        acc_cyc.push_back(k + 1);
        n_issued++;
        #1;
        if (!hold) req_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) check("drain_timeout", 32'(sb.size()), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        cyc       = 0;
        n_checks  = 0;
        n_errors  = 0;
        n_issued  = 0;
        n_rsp     = 0;
        last_rd   = 32'd0;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_wide  = 1'b0;
        req_addr  = 32'd0;
        req_wdata = 32'd0;
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_busy",  32'(busy),      32'd0);
        check("rst_valid", 32'(rsp_valid), 32'd0);
        check("rst_err",   32'(rsp_err),   32'd0);
        check("rst_rdata", rsp_rdata,      32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // T1 narrow write then read
        issue(1'b1, 1'b0, 32'h10, 32'h0000_00A5, 1'b0);
        issue(1'b0, 1'b0, 32'h10, 32'h0, 1'b0);
        drain();

        // T2 wide write, word reads, wide read
        issue(1'b1, 1'b1, 32'h7F0, 32'hDEAD_BEEF, 1'b0);
        issue(1'b0, 1'b0, 32'h7F0, 32'h0, 1'b0);
        issue(1'b0, 1'b0, 32'h7F1, 32'h0, 1'b0);
        issue(1'b0, 1'b1, 32'h7F0, 32'h0, 1'b0);
        drain();

        // T3 range boundaries, no wrap to word 0
        issue(1'b1, 1'b0, 32'h7FF, 32'h0000_1111, 1'b0);
        issue(1'b1, 1'b0, 32'h000, 32'h0000_2222, 1'b0);
        issue(1'b1, 1'b1, 32'h7FF, 32'hCAFE_F00D, 1'b0);
        issue(1'b0, 1'b0, 32'h7FF, 32'h0, 1'b0);
        issue(1'b0, 1'b0, 32'h000, 32'h0, 1'b0);
        issue(1'b0, 1'b0, 32'h800, 32'h0, 1'b0);
        issue(1'b0, 1'b0, 32'h7FF, 32'h0, 1'b0);
        issue(1'b0, 1'b1, 32'h7FF, 32'h0, 1'b0);
        issue(1'b0, 1'b0, 32'hFFFF_0010, 32'h0, 1'b0);
        drain();

        // T4 req_valid held for four back-to-back narrow requests
        acc_cyc.delete();
        for (int i = 0; i < 4; i++) begin
            issue(1'b1, 1'b0, 32'h30 + 32'(i), 32'h0000_A000 + 32'(i), (i != 3) ? 1'b1 : 1'b0);
        end
        drain();
        for (int i = 1; i < 4; i++) begin
            check("b2b_spacing", 32'(acc_cyc[i] - acc_cyc[i-1]), 32'd2);
        end
        for (int i = 0; i < 4; i++) begin
            issue(1'b0, 1'b0, 32'h30 + 32'(i), 32'h0, 1'b0);
        end
        drain();

        // T5 reset during BEAT1 of a wide write
        issue(1'b1, 1'b0, 32'h20, 32'h0000_0000, 1'b0);
        issue(1'b1, 1'b0, 32'h21, 32'h0000_5555, 1'b0);
        issue(1'b0, 1'b0, 32'h21, 32'h0, 1'b0);
        drain();
        req_write = 1'b1;
        req_wide  = 1'b1;
        req_addr  = 32'h20;
        req_wdata = 32'h1234_5678;
        req_valid = 1'b1;
        check("t5_ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("t5_rst_ready", 32'(req_ready), 32'd1);
        check("t5_rst_busy",  32'(busy),      32'd0);
        check("t5_rst_valid", 32'(rsp_valid), 32'd0);
        check("t5_rst_err",   32'(rsp_err),   32'd0);
        check("t5_rst_rdata", rsp_rdata,      32'd0);
        mdl[11'h20] = 16'h1234;
        last_rd     = 32'd0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        issue(1'b0, 1'b0, 32'h20, 32'h0, 1'b0);
        issue(1'b0, 1'b0, 32'h21, 32'h0, 1'b0);
        drain();

        // T6 read-after-write, write keeps previous read data
        issue(1'b1, 1'b0, 32'h40, 32'h0000_BEEF, 1'b0);
        issue(1'b0, 1'b0, 32'h40, 32'h0, 1'b0);
        issue(1'b1, 1'b0, 32'h40, 32'h0000_1357, 1'b0);
        issue(1'b0, 1'b0, 32'h40, 32'h0, 1'b0);
        issue(1'b1, 1'b1, 32'h41, 32'h2468_ACE0, 1'b0);
        issue(1'b0, 1'b1, 32'h40, 32'h0, 1'b0);
        drain();

        repeat (4) @(negedge clk);
        check("sb_empty",  32'(sb.size()), 32'd0);
        check("rsp_count", 32'(n_rsp),     32'(n_issued));
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
